// File: rtl/mem_test_seq.sv
// Memory write/read-back tester: writes DEPTH pattern words, reads them back in order and counts mismatches.
// Optional first-error capture outputs are enabled by defining MEM_TEST_ERR_CAPTURE_EN.
module mem_test_seq #(
  parameter int unsigned       WIDTH   = 32,
  parameter int unsigned       ADDR_W  = 16,
  parameter int unsigned       DEPTH   = 256,
  parameter logic [WIDTH-1:0]  SEED    = '0,
  parameter int unsigned       MAX_OUT = 4,
  parameter int unsigned       TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [WIDTH-1:0]  req_wdata,
  input  logic              rsp_valid,
  input  logic [WIDTH-1:0]  rsp_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [WIDTH-1:0]  err_cnt
`ifdef MEM_TEST_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [WIDTH-1:0]  first_err_data,
  output logic              first_err_vld
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(DEPTH - 1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic             r_start_meta;
  logic             r_start_sync;
  logic             r_start_prev;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_rsp_idx;
  logic [OUT_W-1:0] r_out;
  logic [TMR_W-1:0] r_timer;
  logic [WIDTH-1:0] r_err;
  logic             r_timeout;

  logic             w_wr;
  logic             w_rd_issue;
  logic             w_req_fire;
  logic             w_rsp_ok;
  logic             w_mis;
  logic             w_err_inc;
  logic             w_start_edge;
  logic             w_to_write;
  logic [WIDTH-1:0] w_exp;

  // Reset asserts asynchronously and releases two clocks later, so every other flop sees a clean release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_start_meta <= 1'b0;
      r_start_sync <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_start_meta <= start;
      r_start_sync <= r_start_meta;
      r_start_prev <= r_start_sync;
    end
  end

  assign w_start_edge = r_start_sync & ~r_start_prev;
  assign w_to_write   = w_start_edge && (r_state == S_IDLE || r_state == S_DONE);

  assign w_wr       = (r_state == S_WRITE);
  assign w_rd_issue = (r_state == S_READ) && (r_idx != DEPTH_C) && (r_out != OUT_MAX);
  assign req_valid  = w_wr | w_rd_issue;
  assign req_we     = w_wr;
  assign req_addr   = req_valid ? ADDR_W'(r_idx) : '0;
  assign req_wdata  = w_wr ? (SEED + WIDTH'(r_idx)) : '0;
  assign w_req_fire = req_valid & req_ready;

  // Responses with nothing outstanding, or outside READ, are strays: counted as errors, never compared.
  assign w_exp      = SEED + WIDTH'(r_rsp_idx);
  assign w_rsp_ok   = rsp_valid && (r_state == S_READ) && (r_out != '0);
  assign w_mis      = w_rsp_ok && (rsp_rdata != w_exp);
  assign w_err_inc  = w_mis || (rsp_valid && !w_rsp_ok);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_rsp_idx <= '0;
      r_out     <= '0;
      r_timer   <= '0;
      r_err     <= '0;
      r_timeout <= 1'b0;
    end else if (w_to_write) begin
      r_state   <= S_WRITE;
      r_idx     <= '0;
      r_rsp_idx <= '0;
      r_out     <= '0;
      r_timer   <= '0;
      r_err     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_err_inc && (r_err != '1)) r_err <= r_err + 1'b1;
      case (r_state)
        S_WRITE: begin
          if (w_req_fire) begin
            if (r_idx == LAST_C) begin
              r_state <= S_READ;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_READ: begin
          if (w_req_fire) r_idx <= r_idx + 1'b1;
          if (w_rsp_ok)   r_rsp_idx <= r_rsp_idx + 1'b1;
          r_out <= r_out + OUT_W'(w_req_fire) - OUT_W'(w_rsp_ok);
          if (rsp_valid)         r_timer <= '0;
          else if (r_out != '0)  r_timer <= r_timer + 1'b1;
          if (w_rsp_ok && (r_rsp_idx == LAST_C)) begin
            r_state <= S_DONE;
          end else if (!rsp_valid && (r_out != '0) && (r_timer == TMR_LAST)) begin
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == S_WRITE) || (r_state == S_READ);
  assign done    = (r_state == S_DONE);
  assign pass    = done && (r_err == '0) && !r_timeout;
  assign timeout = r_timeout;
  assign err_cnt = r_err;

`ifdef MEM_TEST_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] r_fe_addr;
  logic [WIDTH-1:0]  r_fe_data;
  logic              r_fe_vld;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_fe_addr <= '0;
      r_fe_data <= '0;
      r_fe_vld  <= 1'b0;
    end else if (w_to_write) begin
      r_fe_addr <= '0;
      r_fe_data <= '0;
      r_fe_vld  <= 1'b0;
    end else if (w_mis && !r_fe_vld) begin
      r_fe_addr <= ADDR_W'(r_rsp_idx);
      r_fe_data <= rsp_rdata;
      r_fe_vld  <= 1'b1;
    end
  end

  assign first_err_addr = r_fe_addr;
  assign first_err_data = r_fe_data;
  assign first_err_vld  = r_fe_vld;
`endif

endmodule

// File: tb/tb_mem_test_seq.sv
// Directed bench for mem_test_seq: behavioural memory with configurable latency, ready stalls and fault injection.
module tb_mem_test_seq;

  localparam logic [31:0] SEED_C = 32'hA5A50000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] err_cnt;
`ifdef MEM_TEST_ERR_CAPTURE_EN
  logic [15:0] first_err_addr;
  logic [31:0] first_err_data;
  logic        first_err_vld;
`endif

  mem_test_seq #(
    .WIDTH(32), .ADDR_W(16), .DEPTH(8), .SEED(SEED_C), .MAX_OUT(2), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt)
`ifdef MEM_TEST_ERR_CAPTURE_EN
    ,
    .first_err_addr(first_err_addr), .first_err_data(first_err_data), .first_err_vld(first_err_vld)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] d;
    int          due;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mem [0:255];
  int          cyc, lat, rsp_limit, rsp_given, last_rsp_cyc;
  bit          rdy_rand, flip, inj, presenting;
  int          wr_n, rd_n, seq_err, stalls, stall_viol, bout, max_out;
  bit          p_stall, p_we;
  logic [15:0] p_addr;
  logic [31:0] p_wd;
  int          vecs, miss;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    q.delete();
    wr_n = 0; rd_n = 0; seq_err = 0; stalls = 0; stall_viol = 0;
    bout = 0; max_out = 0; rsp_given = 0; rsp_limit = 1000000;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1);
  endtask

  // Memory responder: in-order read data after lat cycles, throttled by rsp_limit.
  initial begin
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; cyc = 0; presenting = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (presenting && q.size() > 0) begin
        void'(q.pop_front());
        rsp_given++;
      end
      presenting = 1'b0;
      rsp_rdata  = '0;
      if (q.size() > 0 && q[0].due <= cyc && rsp_given < rsp_limit) begin
        presenting   = 1'b1;
        rsp_rdata    = q[0].d;
        last_rsp_cyc = cyc;
      end
      rsp_valid = presenting | inj;
      req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Request monitor: memory writes, read queueing, ordering, stall stability, outstanding depth.
  initial begin
    p_stall = 1'b0;
    forever begin
      @(negedge clk);
      bout = bout + ((req_valid && req_ready && !req_we) ? 1 : 0) - (presenting ? 1 : 0);
      if (bout > max_out) max_out = bout;
      if (p_stall && (!req_valid || req_we !== p_we || req_addr !== p_addr || req_wdata !== p_wd))
        stall_viol++;
      if (req_valid && req_ready) begin
        if (req_we) begin
          mem[req_addr[7:0]] = (flip && req_addr == 16'd3) ? (req_wdata ^ 32'd1) : req_wdata;
          if (req_addr != 16'(wr_n) || req_wdata != SEED_C + 32'(wr_n)) seq_err++;
          wr_n++;
        end else begin
          q.push_back('{d: mem[req_addr[7:0]], due: cyc + lat});
          if (req_addr != 16'(rd_n)) seq_err++;
          rd_n++;
        end
      end
      p_stall = req_valid && !req_ready;
      p_we    = req_we;
      p_addr  = req_addr;
      p_wd    = req_wdata;
      if (p_stall) stalls++;
    end
  end

  initial begin
    int n;
    int t_seen;
    vecs = 0; miss = 0;
    rst_n = 1'b0; start = 1'b0; inj = 1'b0; lat = 1; rdy_rand = 1'b0; flip = 1'b0;
    last_rsp_cyc = 0;
    clr();

    // Reset state
    @(negedge clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_we", req_we, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_wdata", req_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Start latency and a clean pass
    clr();
    start = 1'b1;
    @(negedge clk); chk("lat_cycle1", req_valid, 0);
    @(negedge clk); chk("lat_cycle2", req_valid, 0);
    @(negedge clk); chk("lat_cycle3", req_valid, 1);
    chk("first_we", req_we, 1);
    chk("first_addr", req_addr, 0);
    chk("first_wdata", req_wdata, 64'hA5A50000);
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done("basic_done", 500);
    chk("basic_pass", pass, 1);
    chk("basic_err", err_cnt, 0);
    chk("basic_timeout", timeout, 0);
    chk("basic_busy", busy, 0);
    chk("basic_writes", wr_n, 8);
    chk("basic_reads", rd_n, 8);
    chk("basic_order", seq_err, 0);
    chk("basic_max_out", max_out, 1);
    chk("done_req_valid", req_valid, 0);

    // Stray response while DONE
    @(negedge clk); inj = 1'b1;
    @(negedge clk); inj = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_err", err_cnt, 1);
    chk("stray_pass", pass, 0);
    chk("stray_done", done, 1);

    // Corrupted word 3
    clr();
    flip = 1'b1;
    pulse_start();
    chk("rerun_err_clear", err_cnt, 0);
    chk("rerun_busy", busy, 1);
    chk("rerun_done", done, 0);
    wait_done("flip_done", 500);
    chk("flip_err", err_cnt, 1);
    chk("flip_pass", pass, 0);
    chk("flip_timeout", timeout, 0);
`ifdef MEM_TEST_ERR_CAPTURE_EN
    chk("flip_fe_addr", first_err_addr, 3);
    chk("flip_fe_data", first_err_data, 64'hA5A50002);
    chk("flip_fe_vld", first_err_vld, 1);
`endif
    flip = 1'b0;

    // Random request backpressure
    clr();
    rdy_rand = 1'b1;
    pulse_start();
    wait_done("stall_done", 2000);
    chk("stall_pass", pass, 1);
    chk("stall_err", err_cnt, 0);
    chk("stall_order", seq_err, 0);
    chk("stall_reads", rd_n, 8);
    chk("stall_seen", stalls > 0, 1);
    chk("stall_stable", stall_viol, 0);
    rdy_rand = 1'b0;

    // Slow memory limited by MAX_OUT
    clr();
    lat = 10;
    pulse_start();
    wait_done("slow_done", 2000);
    chk("slow_max_out", max_out, 2);
    chk("slow_pass", pass, 1);
    chk("slow_err", err_cnt, 0);
    lat = 1;

    // Memory stops after 5 responses
    clr();
    rsp_limit = 5;
    pulse_start();
    n = 0;
    while (!timeout && n < 1000) begin
      @(negedge clk);
      n++;
    end
    t_seen = cyc;
    chk("to_set", timeout, 1);
    chk("to_given", rsp_given, 5);
    chk("to_cycle", t_seen, last_rsp_cyc + 65);
    chk("to_done", done, 1);
    chk("to_pass", pass, 0);
    chk("to_err", err_cnt, 0);
    chk("to_busy", busy, 0);

    // Reset in the middle of READ
    clr();
    lat = 10;
    pulse_start();
    n = 0;
    while (rd_n < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_in_read", rd_n >= 1, 1);
    chk("mid_busy_pre", busy, 1);
    #2;
    rst_n = 1'b0;
    clr();
    #1;
    chk("mid_req_valid", req_valid, 0);
    chk("mid_req_addr", req_addr, 0);
    chk("mid_req_we", req_we, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_err", err_cnt, 0);
    lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clr();
    pulse_start();
    wait_done("post_rst_done", 500);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_reads", rd_n, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
